// File: rtl/clk_mon_pkg.sv
// Shared types and helpers for the divided-clock monitor.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // True when value lies within exp_v +/- tol (unsigned, no wrap).
  function automatic logic in_tol(input int unsigned value, input int unsigned exp_v,
                                  input int unsigned tol);
    if (value >= exp_v) begin
      return (value - exp_v) <= tol;
    end
    return (exp_v - value) <= tol;
  endfunction

endpackage

// File: rtl/clk_div_monitor_sync_edge.sv
// Two-flop synchroniser plus a delay flop; yields the synchronised level and a
// one-cycle rising-edge pulse.
module sync_edge (
  input  logic clk_in,
  input  logic reset,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = d_i;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~s3_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock in clk_in cycles and reports
// lock, sticky error and sticky timeout status.
module clk_div_monitor
  import clk_mon_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned EXP_PERIOD = 16,
  parameter int unsigned EXP_HIGH   = 2,
  parameter int unsigned HIGH_TOL   = 1,
  parameter int unsigned LOCK_CNT   = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             div_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             err,
  output logic             timeout
);

  localparam int unsigned GoodW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic s2, rise;

  sync_edge u_sync_edge (
    .clk_in  (clk_in),
    .reset   (reset),
    .d_i     (div_in),
    .level_o (s2),
    .rise_o  (rise)
  );

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0]   hi_cnt_q, hi_cnt_d;
  logic [GoodW-1:0]   good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   high_q, high_d;
  logic               mv_q, mv_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;
  logic               timeout_q, timeout_d;

  logic             good_meas;
  logic             saturated;
  logic [GoodW-1:0] good_inc;
  logic             lock_reached;

  always_comb begin
    good_meas    = (per_cnt_q == CNT_W'(EXP_PERIOD)) &&
                   in_tol(32'(hi_cnt_q), EXP_HIGH, HIGH_TOL);
    saturated    = (per_cnt_q == CntMax);
    good_inc     = good_cnt_q + GoodW'(1);
    lock_reached = (good_inc == GoodW'(LOCK_CNT));
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a rise in the saturation cycle takes priority over timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (rise) state_d = MEASURE;
      end
      MEASURE: begin
        if (rise) begin
          if (good_meas && lock_reached) state_d = LOCKED;
        end else if (saturated) begin
          state_d = IDLE;
        end
      end
      LOCKED: begin
        if (rise) begin
          if (!good_meas) state_d = MEASURE;
        end else if (saturated) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter and output-register next values
  always_comb begin
    per_cnt_d  = per_cnt_q;
    hi_cnt_d   = hi_cnt_q;
    good_cnt_d = good_cnt_q;
    period_d   = period_q;
    high_d     = high_q;
    mv_d       = 1'b0;
    locked_d   = locked_q;
    err_d      = err_q;
    timeout_d  = timeout_q;

    if (state_q == IDLE) begin
      if (rise) begin
        per_cnt_d = CNT_W'(1);
        hi_cnt_d  = CNT_W'(1);
      end
    end else if (rise) begin
      per_cnt_d = CNT_W'(1);
      hi_cnt_d  = CNT_W'(1);
      period_d  = per_cnt_q;
      high_d    = hi_cnt_q;
      mv_d      = 1'b1;
      if (good_meas) begin
        if (state_q == MEASURE) begin
          good_cnt_d = good_inc;
          if (lock_reached) locked_d = 1'b1;
        end
      end else begin
        good_cnt_d = '0;
        if (state_q == LOCKED) begin
          err_d    = 1'b1;
          locked_d = 1'b0;
        end
      end
    end else if (saturated) begin
      timeout_d  = 1'b1;
      err_d      = 1'b1;
      locked_d   = 1'b0;
      good_cnt_d = '0;
      per_cnt_d  = '0;
      hi_cnt_d   = '0;
    end else begin
      per_cnt_d = per_cnt_q + CNT_W'(1);
      hi_cnt_d  = hi_cnt_q + CNT_W'(s2);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      per_cnt_q  <= '0;
      hi_cnt_q   <= '0;
      good_cnt_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
      mv_q       <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      per_cnt_q  <= per_cnt_d;
      hi_cnt_q   <= hi_cnt_d;
      good_cnt_q <= good_cnt_d;
      period_q   <= period_d;
      high_q     <= high_d;
      mv_q       <= mv_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = mv_q;
  assign locked     = locked_q;
  assign err        = err_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor with hand-computed expectations.
module tb_clk_div_monitor;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       div_in;
  logic [7:0] period, high_time;
  logic       meas_valid, locked, err, timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mv_cnt = 0;
  int mv_cyc = 0;
  int prev_mv_cyc = 0;
  int base;
  logic [7:0] mv_period, mv_high;
  logic       mv_locked, mv_err;

  always #5 clk_in = ~clk_in;

  clk_div_monitor #(
    .CNT_W      (8),
    .EXP_PERIOD (16),
    .EXP_HIGH   (2),
    .HIGH_TOL   (1),
    .LOCK_CNT   (4)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .div_in     (div_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .locked     (locked),
    .err        (err),
    .timeout    (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One clk_in cycle with div_in = d; samples outputs 1ns after the edge.
  task automatic step(input logic d);
    div_in = d;
    @(posedge clk_in);
    #1;
    cyc++;
    if (meas_valid === 1'b1) begin
      mv_cnt++;
      prev_mv_cyc = mv_cyc;
      mv_cyc      = cyc;
      mv_period   = period;
      mv_high     = high_time;
      mv_locked   = locked;
      mv_err      = err;
    end
  endtask

  task automatic run_period(input int hi, input int per);
    for (int i = 0; i < per; i++) step(i < hi);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_period"}, 32'(period), 0);
    chk({tag, "_high"}, 32'(high_time), 0);
    chk({tag, "_mv"}, 32'(meas_valid), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_timeout"}, 32'(timeout), 0);
  endtask

  initial begin
    reset  = 1'b1;
    div_in = 1'b0;
    step(1'b0);
    step(1'b0);
    reset = 1'b0;
    chk_all_zero("reset");

    // Ideal divide-by-16: first edge gives no measurement, lock on 4th strobe.
    base = mv_cnt;
    run_period(2, 16);
    chk("first_edge_no_mv", 32'(mv_cnt - base), 0);
    run_period(2, 16);
    chk("mv1_count", 32'(mv_cnt - base), 1);
    chk("mv1_period", 32'(mv_period), 16);
    chk("mv1_high", 32'(mv_high), 2);
    chk("mv1_locked", 32'(mv_locked), 0);
    run_period(2, 16);
    chk("mv_spacing", 32'(mv_cyc - prev_mv_cyc), 16);
    run_period(2, 16);
    chk("mv3_locked", 32'(mv_locked), 0);
    run_period(2, 16);
    chk("mv4_count", 32'(mv_cnt - base), 4);
    chk("mv4_locked", 32'(mv_locked), 1);
    chk("mv4_err", 32'(mv_err), 0);

    // Stretched period breaks lock and sets err; relock after 4 good periods.
    run_period(2, 17);
    run_period(2, 16);
    chk("stretch_period", 32'(mv_period), 17);
    chk("stretch_locked", 32'(mv_locked), 0);
    chk("stretch_err", 32'(mv_err), 1);
    for (int i = 0; i < 3; i++) run_period(2, 16);
    chk("relock_not_yet", 32'(locked), 0);
    run_period(2, 16);
    chk("relock_locked", 32'(mv_locked), 1);
    chk("relock_err_sticky", 32'(mv_err), 1);

    // High time 3 is within tolerance, 4 is not.
    run_period(3, 16);
    run_period(2, 16);
    chk("hi3_high", 32'(mv_high), 3);
    chk("hi3_locked", 32'(mv_locked), 1);
    run_period(4, 16);
    run_period(2, 16);
    chk("hi4_high", 32'(mv_high), 4);
    chk("hi4_locked", 32'(mv_locked), 0);
    for (int i = 0; i < 4; i++) run_period(2, 16);
    chk("hi_relock", 32'(locked), 1);

    // Hold div_in low: per_cnt saturates 255 cycles after the last rise strobe.
    run_period(2, 16);
    base = mv_cnt;
    for (int i = 16; i < 257; i++) step(1'b0);
    chk("pre_timeout", 32'(timeout), 0);
    chk("pre_timeout_locked", 32'(locked), 1);
    step(1'b0);
    chk("timeout", 32'(timeout), 1);
    chk("timeout_err", 32'(err), 1);
    chk("timeout_locked", 32'(locked), 0);
    chk("timeout_no_mv", 32'(mv_cnt - base), 0);

    // Back in IDLE: first edge gives no strobe, lock after 1+4 edges.
    base = mv_cnt;
    run_period(2, 16);
    chk("idle_no_mv", 32'(mv_cnt - base), 0);
    for (int i = 0; i < 3; i++) run_period(2, 16);
    chk("to_relock_not_yet", 32'(locked), 0);
    run_period(2, 16);
    chk("to_relock", 32'(locked), 1);
    chk("to_timeout_sticky", 32'(timeout), 1);

    // Reset mid-period while locked.
    step(1'b1);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    step(1'b0);
    reset = 1'b1;
    step(1'b0);
    reset = 1'b0;
    chk_all_zero("midreset");
    base = mv_cnt;
    run_period(2, 16);
    chk("post_reset_first_edge", 32'(mv_cnt - base), 0);
    run_period(2, 16);
    chk("post_reset_mv", 32'(mv_cnt - base), 1);
    chk("post_reset_period", 32'(mv_period), 16);
    chk("post_reset_err", 32'(mv_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
